lsu_mem_master: RTL and testbench
=================================

# lsu_mem_master

Load/store initiator between the core's memory stage and the word-addressed data memory. It accepts one RV32I load or store request at a time and issues word-aligned accesses on the data-memory port (`lsu_wren` / `data_addr` / `data`). It performs byte/halfword lane extraction with sign or zero extension for loads, and read-modify-write for sub-word stores. It returns a single-cycle response to the core.

## Interface
- `ADDR_W`, 16, byte address width, shared by the core and memory ports.
- `DATA_W`, 32, data word width. Fixed at 32; other values are not supported.

Reset is synchronous and active-high.

- `i_clk`  in  1  clock; all state updates on the rising edge.
- `i_rst`  in  1  synchronous active-high reset.
- `i_req_valid`  in  1  core request valid.
- `o_req_ready`  out  1  block can accept a request. A request is accepted on an edge where `i_req_valid` and `o_req_ready` are both 1.
- `i_req_we`  in  1  1 = store, 0 = load.
- `i_req_funct3`  in  3  RV32I size and sign.
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
- `i_req_addr`  in  ADDR_W  byte address.
- `i_req_wdata`  in  DATA_W  store data, right-aligned.
- `o_rsp_valid`  out  1  response strobe, one cycle.
- `o_rsp_rdata`  out  DATA_W  extended load data. 0 for stores and errors.
- `o_rsp_err`  out  1  misaligned access or illegal `funct3`.
- `o_lsu_wren`  out  1  memory write enable.
- `o_data_addr`  out  ADDR_W  word-aligned memory address, `{addr[15:2],2'b00}`.
- `o_data`  out  DATA_W  memory write data.
- `i_data`  in  DATA_W  memory read data. Valid in the cycle after the address has been held for one full cycle (synchronous read).

## Operation
- States:
  - IDLE: the only accepting state.
  - RD_ADDR: drives the read address.
  - RD_DATA: samples `i_data` at the end of the cycle.
  - WR: drives the write.
  - RSP: asserts the response.
- Request fields are captured at accept. Core inputs are ignored outside IDLE.
- Error check at accept, which takes precedence over everything else. A request is an error when:
  - LH/LHU/SH has `addr[0]` = 1, or
  - LW/SW has `addr[1:0]` ≠ 0, or
  - load `funct3` is 011, 110 or 111, or
  - store `funct3` is anything other than 000, 001 or 010.
  - Error path: IDLE→RSP with err = 1 and rdata = 0. No memory access.
- Transitions by request type:
  - Load: IDLE→RD_ADDR→RD_DATA→RSP.
  - SW: IDLE→WR→RSP.
  - SB/SH: IDLE→RD_ADDR→RD_DATA→WR→RSP.
  - RSP always→IDLE.
- Load extraction:
  - Byte lane = `addr[1:0]`; halfword lane = `addr[1]`.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- Store merge (SB/SH): take the old word sampled in RD_DATA, replace the lane selected by the address with `wdata[7:0]` (SB) or `wdata[15:0]` (SH), and drive the result on `o_data` in WR. SW drives `wdata` directly.
- `o_data_addr` is held constant from RD_ADDR through WR and is 0 in IDLE/RSP.
- `o_data` is 0 outside WR.
- `o_lsu_wren` = (state == WR) && !`i_rst`. It is high for exactly one cycle per store.

## Timing
- Reset: state = IDLE. `o_rsp_valid`, `o_rsp_rdata`, `o_rsp_err`, `o_lsu_wren`, `o_data_addr` and `o_data` are all 0. `o_req_ready` = 0 while `i_rst` = 1.
- `o_req_ready` = (state == IDLE) && !`i_rst`. It is combinational from state.
- Latency from the accept edge to the cycle with `o_rsp_valid` = 1:
  - error: 1 cycle.
  - SW: 2 cycles.
  - load: 3 cycles.
  - SB/SH: 4 cycles.
- Throughput: the next accept happens at the earliest on the edge ending the cycle after RSP, since state is IDLE then. There is no overlap between requests.
- `o_rsp_valid` is high for exactly one cycle. There is no backpressure on the response.
- Reset mid-operation: the transaction is aborted with no response. Reset during the WR cycle suppresses the write (`o_lsu_wren` gated low). The block is ready in the first cycle with `i_rst` = 0.
- A request held valid across an accept is taken once. A new accept requires IDLE.

## Test plan
- SW 0x2000 wdata 0xDEADBEEF → `o_lsu_wren` = 1 for one cycle with addr 0x2000 and data 0xDEADBEEF; rsp 2 cycles after accept with err = 0. Then LW 0x2000 → rsp 3 cycles after accept with rdata 0xDEADBEEF.
- Memory at 0x2004 = 0x12345678.
  - SB 0x2005 wdata 0xAA → write 0x1234AA78.
  - LB 0x2005 → 0xFFFFFFAA.
  - LBU 0x2005 → 0x000000AA.
- Memory at 0x2008 = 0xCAFEBABE.
  - SH 0x200A wdata 0x1234 → write 0x1234BABE.
  - LHU 0x200A → 0x00001234.
  - LH 0x2008 → 0xFFFFBABE.
- Error requests: LW 0x2002, SH 0x2001, load `funct3` 011 → each gives rsp 1 cycle after accept with err = 1 and rdata = 0. `o_lsu_wren` is never asserted and memory is unchanged.
- SB 0x2004 with `i_rst` asserted during the WR cycle → no write, no rsp. `o_req_ready` = 1 in the first cycle after reset deasserts. LW 0x2004 then returns the old value.
- `i_req_valid` held high with two queued loads → `o_req_ready` drops after the first accept. The second load is accepted in the cycle after the first RSP. Each load gets exactly one rsp, in order.

Source files
------------

// File: rtl/lsu_mem_master.sv
// lsu_mem_master: load/store initiator from the core memory stage to a
// word-addressed synchronous-read data memory.
//
// Ports:
//   i_clk, i_rst       clock, synchronous active-high reset
//   i_req_valid        core request valid
//   o_req_ready        request accepted when valid && ready (IDLE only)
//   i_req_we           1 = store, 0 = load
//   i_req_funct3       RV32I size/sign field
//   i_req_addr         byte address
//   i_req_wdata        store data, right-aligned
//   o_rsp_valid        one-cycle response strobe
//   o_rsp_rdata        extended load data (0 for stores and errors)
//   o_rsp_err          misaligned access or illegal funct3
//   o_lsu_wren         memory write enable (one cycle per store)
//   o_data_addr        word-aligned memory address
//   o_data             memory write data
//   i_data             memory read data (one cycle after address)
module lsu_mem_master #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_we,
    input  logic [2:0]        i_req_funct3,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic [DATA_W-1:0] i_req_wdata,
    output logic              o_rsp_valid,
    output logic [DATA_W-1:0] o_rsp_rdata,
    output logic              o_rsp_err,
    output logic              o_lsu_wren,
    output logic [ADDR_W-1:0] o_data_addr,
    output logic [DATA_W-1:0] o_data,
    input  logic [DATA_W-1:0] i_data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_ADDR,
        S_RD_DATA,
        S_WR,
        S_RSP
    } state_t;

    state_t              r_state;
    logic                r_we;
    logic [2:0]          r_funct3;
    logic [1:0]          r_lane;
    logic [15:0]         r_wdata;
    logic                r_rsp_valid;
    logic [DATA_W-1:0]   r_rsp_rdata;
    logic                r_rsp_err;
    logic [ADDR_W-1:0]   r_data_addr;
    logic [DATA_W-1:0]   r_data;

    logic                w_accept;
    logic                w_err;
    logic [ADDR_W-1:0]   w_word_addr;
    logic [7:0]          w_byte;
    logic [15:0]         w_half;
    logic [DATA_W-1:0]   w_load;
    logic [DATA_W-1:0]   w_merge;

    assign o_req_ready = (r_state == S_IDLE) && !i_rst;
    assign o_lsu_wren  = (r_state == S_WR) && !i_rst;
    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_rdata = r_rsp_rdata;
    assign o_rsp_err   = r_rsp_err;
    assign o_data_addr = r_data_addr;
    assign o_data      = r_data;

    assign w_accept    = i_req_valid && o_req_ready;
    assign w_word_addr = {i_req_addr[ADDR_W-1:2], 2'b00};

    always_comb begin
        w_err = 1'b0;
        if (i_req_we) begin
            case (i_req_funct3)
                3'b000:  w_err = 1'b0;
                3'b001:  w_err = i_req_addr[0];
                3'b010:  w_err = |i_req_addr[1:0];
                default: w_err = 1'b1;
            endcase
        end else begin
            case (i_req_funct3)
                3'b000, 3'b100: w_err = 1'b0;
                3'b001, 3'b101: w_err = i_req_addr[0];
                3'b010:         w_err = |i_req_addr[1:0];
                default:        w_err = 1'b1;
            endcase
        end
    end

    // Lane selection from the word returned by memory.
    assign w_byte = i_data[{r_lane, 3'b000} +: 8];
    assign w_half = i_data[{r_lane[1], 4'b0000} +: 16];

    always_comb begin
        case (r_funct3)
            3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load = {{16{w_half[15]}}, w_half};
            3'b100:  w_load = {24'd0, w_byte};
            3'b101:  w_load = {16'd0, w_half};
            default: w_load = i_data;
        endcase
    end

    // Sub-word store: overlay the new lane on the old word.
    always_comb begin
        w_merge = i_data;
        if (r_funct3[0]) begin
            w_merge[{r_lane[1], 4'b0000} +: 16] = r_wdata;
        end else begin
            w_merge[{r_lane, 3'b000} +: 8] = r_wdata[7:0];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_we        <= 1'b0;
            r_funct3    <= 3'b000;
            r_lane      <= 2'b00;
            r_wdata     <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            r_data_addr <= '0;
            r_data      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_we     <= i_req_we;
                        r_funct3 <= i_req_funct3;
                        r_lane   <= i_req_addr[1:0];
                        r_wdata  <= i_req_wdata[15:0];
                        if (w_err) begin
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= 1'b1;
                            r_rsp_rdata <= '0;
                            r_state     <= S_RSP;
                        end else if (i_req_we &&
                                     i_req_funct3 == 3'b010) begin
                            r_data_addr <= w_word_addr;
                            r_data      <= i_req_wdata;
                            r_state     <= S_WR;
                        end else begin
                            r_data_addr <= w_word_addr;
                            r_state     <= S_RD_ADDR;
                        end
                    end
                end
                S_RD_ADDR: begin
                    r_state <= S_RD_DATA;
                end
                S_RD_DATA: begin
                    if (r_we) begin
                        r_data  <= w_merge;
                        r_state <= S_WR;
                    end else begin
                        r_rsp_rdata <= w_load;
                        r_rsp_valid <= 1'b1;
                        r_data_addr <= '0;
                        r_state     <= S_RSP;
                    end
                end
                S_WR: begin
                    r_data      <= '0;
                    r_data_addr <= '0;
                    r_rsp_valid <= 1'b1;
                    r_state     <= S_RSP;
                end
                S_RSP: begin
                    r_rsp_valid <= 1'b0;
                    r_rsp_err   <= 1'b0;
                    r_rsp_rdata <= '0;
                    r_state     <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_master.sv
// tb_lsu_mem_master: directed bench for lsu_mem_master with a
// synchronous-read word memory model and write monitor.
module tb_lsu_mem_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [15:0] req_addr = 16'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        lsu_wren;
    logic [15:0] data_addr;
    logic [31:0] data_out;
    logic [31:0] data_in;

    logic [31:0] mem [0:16383];
    int          wr_count = 0;
    logic [15:0] last_wa = 16'h0;
    logic [31:0] last_wd = 32'h0;

    int n_checks = 0;
    int n_errors = 0;

    lsu_mem_master #(.ADDR_W(16), .DATA_W(32)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_req_valid  (req_valid),
        .o_req_ready  (req_ready),
        .i_req_we     (req_we),
        .i_req_funct3 (req_funct3),
        .i_req_addr   (req_addr),
        .i_req_wdata  (req_wdata),
        .o_rsp_valid  (rsp_valid),
        .o_rsp_rdata  (rsp_rdata),
        .o_rsp_err    (rsp_err),
        .o_lsu_wren   (lsu_wren),
        .o_data_addr  (data_addr),
        .o_data       (data_out),
        .i_data       (data_in)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (lsu_wren) begin
            mem[data_addr[15:2]] <= data_out;
            wr_count <= wr_count + 1;
            last_wa  <= data_addr;
            last_wd  <= data_out;
        end
        data_in <= mem[data_addr[15:2]];
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_req(input string tag, input logic we,
                          input logic [2:0] f3, input logic [15:0] addr,
                          input logic [31:0] wd, input int exp_lat,
                          input logic exp_err, input logic [31:0] exp_rd,
                          input int exp_wr, input logic [15:0] exp_wa,
                          input logic [31:0] exp_wd);
        int n0;
        int lat;
        int k;
        n0 = wr_count;
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        k = 0;
        while (!req_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        check({tag, " ready"}, 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 12) begin
            @(negedge clk);
            lat++;
        end
        check({tag, " latency"}, lat, exp_lat);
        check({tag, " err"}, 32'(rsp_err), 32'(exp_err));
        check({tag, " rdata"}, rsp_rdata, exp_rd);
        check({tag, " rsp addr0"}, 32'(data_addr), 32'd0);
        @(negedge clk);
        check({tag, " rsp one cycle"}, 32'(rsp_valid), 32'd0);
        check({tag, " writes"}, wr_count - n0, exp_wr);
        if (exp_wr > 0) begin
            check({tag, " waddr"}, 32'(last_wa), 32'(exp_wa));
            check({tag, " wdata"}, last_wd, exp_wd);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int n0;
        int seen;
        int acc;
        int acc2_c;
        int nrsp;
        int rsp_c [0:3];
        logic [31:0] rsp_d [0:3];
        logic sw_fields;
        logic drop_valid;

        repeat (2) @(negedge clk);
        check("rst ready", 32'(req_ready), 32'd0);
        check("rst rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst rdata", rsp_rdata, 32'd0);
        check("rst err", 32'(rsp_err), 32'd0);
        check("rst wren", 32'(lsu_wren), 32'd0);
        check("rst addr", 32'(data_addr), 32'd0);
        check("rst data", data_out, 32'd0);
        rst = 1'b0;
        #1;
        check("post rst ready", 32'(req_ready), 32'd1);

        do_req("SW", 1, 3'b010, 16'h2000, 32'hDEADBEEF,
               2, 0, 32'h0, 1, 16'h2000, 32'hDEADBEEF);
        do_req("LW", 0, 3'b010, 16'h2000, 32'h0,
               3, 0, 32'hDEADBEEF, 0, 16'h0, 32'h0);
        do_req("SW4", 1, 3'b010, 16'h2004, 32'h12345678,
               2, 0, 32'h0, 1, 16'h2004, 32'h12345678);
        do_req("SW8", 1, 3'b010, 16'h2008, 32'hCAFEBABE,
               2, 0, 32'h0, 1, 16'h2008, 32'hCAFEBABE);
        do_req("SB", 1, 3'b000, 16'h2005, 32'h123456AA,
               4, 0, 32'h0, 1, 16'h2004, 32'h1234AA78);
        do_req("LB", 0, 3'b000, 16'h2005, 32'h0,
               3, 0, 32'hFFFFFFAA, 0, 16'h0, 32'h0);
        do_req("LBU", 0, 3'b100, 16'h2005, 32'h0,
               3, 0, 32'h000000AA, 0, 16'h0, 32'h0);
        do_req("SH", 1, 3'b001, 16'h200A, 32'hABCD1234,
               4, 0, 32'h0, 1, 16'h2008, 32'h1234BABE);
        do_req("LHU", 0, 3'b101, 16'h200A, 32'h0,
               3, 0, 32'h00001234, 0, 16'h0, 32'h0);
        do_req("LH", 0, 3'b001, 16'h2008, 32'h0,
               3, 0, 32'hFFFFBABE, 0, 16'h0, 32'h0);
        do_req("LB0", 0, 3'b000, 16'h2004, 32'h0,
               3, 0, 32'h00000078, 0, 16'h0, 32'h0);

        do_req("E LW2", 0, 3'b010, 16'h2002, 32'h0,
               1, 1, 32'h0, 0, 16'h0, 32'h0);
        do_req("E SH1", 1, 3'b001, 16'h2001, 32'hFFFF,
               1, 1, 32'h0, 0, 16'h0, 32'h0);
        do_req("E LD011", 0, 3'b011, 16'h2000, 32'h0,
               1, 1, 32'h0, 0, 16'h0, 32'h0);
        do_req("E ST100", 1, 3'b100, 16'h2000, 32'h5555,
               1, 1, 32'h0, 0, 16'h0, 32'h0);
        do_req("LW after err", 0, 3'b010, 16'h2000, 32'h0,
               3, 0, 32'hDEADBEEF, 0, 16'h0, 32'h0);

        // Reset landing on the WR cycle of an SB.
        n0 = wr_count;
        seen = 0;
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'b000;
        req_addr   = 16'h2004;
        req_wdata  = 32'h77;
        check("rstwr ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        if (rsp_valid) seen++;
        @(negedge clk);
        if (rsp_valid) seen++;
        @(negedge clk);
        check("rstwr wren pre", 32'(lsu_wren), 32'd1);
        rst = 1'b1;
        #1;
        check("rstwr wren gated", 32'(lsu_wren), 32'd0);
        check("rstwr ready in rst", 32'(req_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rstwr ready after", 32'(req_ready), 32'd1);
        check("rstwr addr", 32'(data_addr), 32'd0);
        check("rstwr data", data_out, 32'd0);
        repeat (4) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        check("rstwr no rsp", seen, 0);
        check("rstwr no write", wr_count - n0, 0);
        do_req("LW old", 0, 3'b010, 16'h2004, 32'h0,
               3, 0, 32'h1234AA78, 0, 16'h0, 32'h0);

        // Two back-to-back loads with valid held high.
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_funct3 = 3'b010;
        req_addr   = 16'h2000;
        acc = 0;
        acc2_c = -1;
        nrsp = 0;
        sw_fields = 1'b0;
        drop_valid = 1'b0;
        for (int c = 0; c < 14; c++) begin
            if (c > 0) @(negedge clk);
            if (sw_fields) begin
                req_addr = 16'h2008;
                sw_fields = 1'b0;
            end
            if (drop_valid) begin
                req_valid = 1'b0;
                drop_valid = 1'b0;
            end
            if (c == 1) check("q ready drop", 32'(req_ready), 32'd0);
            if (rsp_valid) begin
                if (nrsp < 4) begin
                    rsp_c[nrsp] = c;
                    rsp_d[nrsp] = rsp_rdata;
                end
                nrsp++;
            end
            if (req_valid && req_ready) begin
                acc++;
                if (acc == 1) sw_fields = 1'b1;
                if (acc == 2) begin
                    acc2_c = c;
                    drop_valid = 1'b1;
                end
            end
        end
        check("q accepts", acc, 2);
        check("q accept2 cycle", acc2_c, 4);
        check("q rsp count", nrsp, 2);
        if (nrsp >= 2) begin
            check("q rsp1 cycle", rsp_c[0], 3);
            check("q rsp1 data", rsp_d[0], 32'hDEADBEEF);
            check("q rsp2 cycle", rsp_c[1], 7);
            check("q rsp2 data", rsp_d[1], 32'h1234BABE);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
